// File: rtl/fifo_access_sched.sv
// Shared-access scheduler in front of a 16-entry counting FIFO: round-robin write arbitration
// with bounded bursts, and read/write collision resolution by alternating priority.
module fifo_access_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic                 wack,
  input  logic                 rd_req,
  output logic                 rack,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  output logic                 fifo_wr,
  output logic                 fifo_rd,
  output logic [DW-1:0]        fifo_din,
  output logic [2:0]           owner
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      last_q, last_d;
  logic [3:0]      beat_q, beat_d;
  logic            rd_pri_q, rd_pri_d;

  logic            found;
  logic [2:0]      winner;
  logic            req_own;
  logic            wr_pend, rd_pend;
  logic            wr_go, rd_go;
  logic [DW-1:0]   din;

  // Round-robin search: first set bit above last, then wrap to the bits at or below last.
  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (j > int'(last_q))) begin
        found  = 1'b1;
        winner = 3'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (j <= int'(last_q))) begin
        found  = 1'b1;
        winner = 3'(j);
      end
    end
  end

  // gnt_q is one-hot on the owner while bursting, so masking avoids a wide index.
  assign req_own = |(req & gnt_q);

  always_comb begin
    din = '0;
    if (state_q == StBurst) begin
      for (int j = 0; j < NREQ; j++) begin
        if (gnt_q[j]) din = wdata[j*DW +: DW];
      end
    end
  end

  assign wr_pend = (state_q == StBurst) && req_own && !fifo_full;
  assign rd_pend = rd_req && !fifo_empty;
  assign wr_go   = wr_pend && !(rd_pend && rd_pri_q);
  assign rd_go   = rd_pend && !(wr_pend && !rd_pri_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    beat_d   = beat_q;
    rd_pri_d = (wr_pend && rd_pend) ? !rd_pri_q : rd_pri_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StBurst;
          for (int j = 0; j < NREQ; j++) gnt_d[j] = (3'(j) == winner);
          owner_d = winner;
          last_d  = winner;
          beat_d  = 4'd0;
        end
      end
      StBurst: begin
        if (wr_go) beat_d = beat_q + 4'd1;
        if (!req_own || (wr_go && (beat_q == 4'(MAX_BURST - 1)))) begin
          state_d = StIdle;
          gnt_d   = '0;
          owner_d = 3'd0;
          beat_d  = 4'd0;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        owner_d = 3'd0;
        beat_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      owner_q  <= 3'd0;
      last_q   <= 3'(NREQ - 1);
      beat_q   <= 4'd0;
      rd_pri_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      beat_q   <= beat_d;
      rd_pri_q <= rd_pri_d;
    end
  end

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign wack     = wr_go;
  assign fifo_wr  = wr_go;
  assign rack     = rd_go;
  assign fifo_rd  = rd_go;
  assign fifo_din = din;

endmodule

// File: doc/fifo_access_sched.md
Name: fifo_access_sched

Overview:
- Shared-access scheduler in front of the 16-entry counting FIFO.
- Arbitrates NREQ write requesters round-robin with bounded bursts, and drives the FIFO's wr/rd/din strobes.
- The FIFO treats wr and rd in the same cycle as a no-op, so this block never asserts both together. It resolves write/read collisions by alternating priority.
- Sits between producer agents and the FIFO, with one consumer on the read side.

Parameters:
NREQ, 4, number of write requesters (2..8)
DW, 8, data width; matches FIFO din
MAX_BURST, 4, maximum accepted beats per grant (1..15)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester write request; held while data is valid
wdata  input  NREQ*DW  per-requester data; requester i uses bits [i*DW +: DW]
gnt  output  NREQ  one-hot registered grant, or all-zero
wack  output  1  beat accepted this cycle for the granted requester
rd_req  input  1  consumer read request (level)
rack  output  1  read accepted this cycle
fifo_full  input  1  from FIFO
fifo_empty  input  1  from FIFO
fifo_wr  output  1  FIFO write strobe
fifo_rd  output  1  FIFO read strobe
fifo_din  output  DW  FIFO write data
owner  output  3  index of the granted requester; 0 when idle

Behaviour:
- Reset: rst_n is asynchronous and active-low. When rst_n=0, all state clears immediately, regardless of clk.
  - state=IDLE, gnt=0, owner=0, beat_cnt=0, last=NREQ-1, rd_pri=0.
  - Combinational outputs follow from this state: fifo_wr=0, wack=0, fifo_din=0.
  - fifo_rd and rack still follow rd_req && !fifo_empty, because no write is pending in IDLE.
- FSM state IDLE:
  - If any req bit is set, pick the first set bit searching upward from last+1 with wrap.
  - Register gnt/owner and set last=winner. beat_cnt=0. Go to BURST.
  - Arbitration latency: 1 cycle from req to gnt; no beat is accepted in the arbitration cycle.
- Write pending: wr_pend = (state==BURST) && req[owner] && !fifo_full.
- Read pending: rd_pend = rd_req && !fifo_empty.
- Collision (wr_pend && rd_pend):
  - If rd_pri=1, the read wins; otherwise the write wins.
  - rd_pri toggles after every collision cycle.
  - rd_pri is unchanged when there is no collision.
- Strobes:
  - fifo_wr = wack = wr_pend && !(rd_pend && rd_pri).
  - fifo_rd = rack = rd_pend && !(wr_pend && !rd_pri).
  - fifo_wr and fifo_rd are never both 1.
  - fifo_din = wdata slice of owner when in BURST, else 0.
- FSM state BURST:
  - Each wack increments beat_cnt.
  - Go to IDLE (gnt cleared next cycle) when req[owner]=0, or when wack occurs with beat_cnt==MAX_BURST-1.
  - A stall (fifo_full, or losing a collision) holds the grant and does not count as a beat.
  - After IDLE, re-arbitration starts from last+1, so a continuously requesting agent yields once the others request.
- Full/empty:
  - No fifo_wr while fifo_full.
  - No fifo_rd while fifo_empty.
  - Both are evaluated combinationally in the same cycle.
- Requester protocol:
  - Deasserting req mid-burst ends the grant.
  - wdata must be stable while req && gnt.
- Widths: beat_cnt is 4 bits; last and owner are 3 bits. Unused owner MSBs are 0 when NREQ<8.
- Reset mid-burst: the grant drops asynchronously, and any in-flight beat is not issued.

Test Plan:
- Single requester: req[2]=1 continuously with the FIFO empty → gnt=0100 one cycle after req; wack on 4 consecutive cycles; gnt drops for 1 cycle; re-grant to requester 2; 16 total writes then stall on full with gnt held.
- Round-robin: req=1111 held → grant order 0,1,2,3,0, each with 4 beats. No requester gets two consecutive grants while others request.
- Collision: owner writing with rd_req=1 and the FIFO non-empty → the first collision writes (rd_pri=0), the next reads, then alternating. fifo_wr&fifo_rd is never 1; the bench's occupancy model matches the FIFO count.
- Full/empty boundary: FIFO filled to 16, req[1]=1 and rd_req=1 → read issues; next cycle the write issues (full clears), with count 16→15→16. With the FIFO empty and rd_req=1 alone → fifo_rd=0, rack=0.
- Early release: req[3] drops after 2 beats → IDLE next cycle and the next requester is granted. beat_cnt restarts at 0.
- Async reset: assert rst_n=0 mid-burst between clock edges → gnt, fifo_wr and wack go to 0 immediately. After release the first grant goes to requester 0 (last=NREQ-1).
